tri_bus_arbiter: RTL and testbench
==================================

TRI_BUS_ARBITER -- requirements
Module: tri_bus_arbiter

Interface
REQ-001 SHALL have parameter TENURE, default 8: maximum owned cycles before forced release when another requester is pending; legal 2..255.
REQ-002 SHALL have parameter TURN, default 1: dead cycles, with all enables low, between two ownerships; legal 1..15.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  4  level request per requester, bit k = requester k, sampled on clk.
REQ-006 SHALL have port grant  output  4  one-hot ownership, registered.
REQ-007 SHALL have port oe  output  4  tri-state buffer Ctrl enables for the shared bus, registered, one-hot or zero.
REQ-008 SHALL have port owner  output  2  binary index of the current owner, valid only when bus_busy=1, else 0.
REQ-009 SHALL have port bus_busy  output  1  high when any oe bit is high.
REQ-010 SHALL have port turn  output  1  high during turnaround dead cycles.

Function
REQ-011 SHALL implement the FSM states IDLE, OWN and TURNAR.
REQ-012 In IDLE, grant, oe, owner, bus_busy and turn SHALL be 0.
REQ-013 In IDLE, if req!=0 at an edge, the FSM SHALL go to OWN and assert grant[k]=oe[k]=1 on the next cycle (1-cycle latency), where k is the round-robin winner.
REQ-014 Round-robin SHALL search k = ptr, ptr+1, ... mod 4 and pick the first set req bit; ptr resets to 0.
REQ-015 On leaving OWN from owner k, ptr SHALL become (k+1) mod 4.
REQ-016 In OWN, grant and oe SHALL equal the same one-hot vector, never more than one bit set, and SHALL hold stable for the whole tenure.
REQ-017 A tenure counter SHALL clear on OWN entry, increment each OWN cycle and saturate at TENURE.
REQ-018 OWN SHALL exit to TURNAR when req[owner] samples 0 (voluntary release).
REQ-019 OWN SHALL also exit to TURNAR when counter==TENURE and any other req bit is 1 (forced release).
REQ-020 If counter==TENURE and no other request is pending, the owner SHALL keep the bus indefinitely.
REQ-021 On entering TURNAR, grant and oe SHALL go to 0 on the same edge, and turn SHALL go to 1.
REQ-022 TURNAR SHALL last exactly TURN cycles.
REQ-023 At the last TURNAR edge, if req!=0 the FSM SHALL go to OWN with the round-robin winner using the updated ptr; otherwise it SHALL go to IDLE.
REQ-024 Back-to-back owners SHALL therefore always be separated by exactly TURN cycles with oe=0, and two oe bits SHALL never be high in the same cycle or in adjacent cycles.
REQ-025 A requester dropping req while another holds the bus SHALL have no effect; requests SHALL NOT be latched.
REQ-026 req changes during TURNAR before the final edge SHALL be ignored; only the final-edge value counts.
REQ-027 A forced-release owner that keeps req high SHALL compete again normally after TURNAR, at the lowest priority.
REQ-028 Simultaneous release by the owner and new requests SHALL still pass through TURNAR, with no shortcut.

Reset
REQ-029 rst_n=0 SHALL immediately and asynchronously force state=IDLE, ptr=0, counter=0 and grant=oe=owner=bus_busy=turn=0, including mid-tenure and mid-turnaround.
REQ-030 After rst_n deasserts, the first grant SHALL occur no earlier than the second rising edge after deassertion, under the IDLE rule of REQ-013.

Verification
REQ-031 The bench SHALL cover this scenario: reset, then req=0001 held 3 cycles and dropped -> oe=0001 from cycle 1 to 3, then turn=1 for 1 cycle, then IDLE with all outputs 0.
REQ-032 The bench SHALL cover this scenario: req=1111 held constantly with TENURE=8 and TURN=1 -> owners 0,1,2,3,0 in order, each oe pulse 8 cycles, 1 dead cycle between pulses, never 2 oe bits high.
REQ-033 The bench SHALL cover this scenario: req=0100 only, held 20 cycles -> oe=0100 for all 20 cycles with no forced release; then req=0110 -> release at the next edge, 1 dead cycle, oe=0010 no wait.
REQ-034 The bench SHALL cover this scenario: owner 1 releasing while req=1001 arrives -> TURNAR, then owner 3 wins (ptr=2) ahead of 0.
REQ-035 The bench SHALL cover this scenario: rst_n pulsed low mid-tenure, async relative to clk -> all outputs 0 before the next clk edge; after release with req=0010, grant=0010 with ptr restarted at 0.
REQ-036 The bench SHALL cover this scenario: TURN=3 with req=0011 constant -> exactly 3 cycles with turn=1 and oe=0 between owners; plus a continuous assertion that popcount(oe)<=1 and oe==grant.

Source files
------------

// File: rtl/tri_bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// tri_bus_arbiter_if
// Bundle of the request/ownership signals between four bus requesters and the
// tri-state bus arbiter.
//   req      : level request per requester (bit k = requester k)
//   grant    : one-hot ownership
//   oe       : tri-state buffer enables for the shared bus, one-hot or zero
//   owner    : binary index of the current owner, 0 when the bus is free
//   bus_busy : high while any oe bit is high
//   turn     : high during turnaround dead cycles
// master = requester side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface tri_bus_arbiter_if;
    logic [3:0] req;
    logic [3:0] grant;
    logic [3:0] oe;
    logic [1:0] owner;
    logic       bus_busy;
    logic       turn;

    modport master (
        output req,
        input  grant,
        input  oe,
        input  owner,
        input  bus_busy,
        input  turn
    );

    modport slave (
        input  req,
        output grant,
        output oe,
        output owner,
        output bus_busy,
        output turn
    );
endinterface

// File: rtl/tri_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tri_bus_arbiter
// Round-robin arbiter for four requesters sharing one tri-state bus. An owner
// keeps the bus until it drops its request, or until it has held it TENURE
// cycles while someone else is waiting. Every change of owner passes through
// TURN dead cycles with all enables low so two drivers never overlap.
// Ports:
//   clk   : single clock, all state on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : tri_bus_arbiter_if.slave (req in; grant, oe, owner, bus_busy,
//           turn out)
// Parameters:
//   TENURE : owned cycles before a forced release when others wait (2..255)
//   TURN   : dead cycles between two ownerships (1..15)
// ---------------------------------------------------------------------------
module tri_bus_arbiter #(
    parameter int TENURE = 8,
    parameter int TURN   = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    tri_bus_arbiter_if.slave  bus
);

    localparam logic [7:0] TENURE_MAX = 8'(TENURE);
    localparam logic [3:0] TURN_LAST  = 4'(TURN - 1);

    typedef enum logic [1:0] {
        IDLE,
        OWN,
        TURNAR
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] ptr, ptr_nxt;
    logic [7:0] tenure_cnt, tenure_cnt_nxt;
    logic [3:0] turn_cnt, turn_cnt_nxt;
    logic [3:0] grant_q, grant_nxt;
    logic [1:0] owner_q, owner_nxt;
    logic       armed;
    logic [1:0] winner;
    logic       found;
    logic       others_pending;

    // The arbiter refuses to grant on the very first edge after reset is
    // released. That edge only arms it, so a reset release landing close to a
    // clock edge can never produce a grant on that same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
        end
    end

    // Round-robin search starting at ptr and wrapping modulo 4; the 2-bit
    // index addition provides the wrap. The first set request wins.
    always_comb begin
        logic [1:0] idx;
        idx    = '0;
        winner = ptr;
        found  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + i[1:0];
            if (!found && bus.req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    // While someone owns the bus, grant_q holds the owner's one-hot bit, so
    // masking it out leaves only the competing requests.
    assign others_pending = |(bus.req & ~grant_q);

    // Next-state logic. The tenure counter holds the number of OWN cycles
    // elapsed including the current one: it restarts at 1 on entry, so an
    // owner forced out at TENURE has driven the bus exactly TENURE cycles.
    // Leaving OWN clears grant on that same edge and moves the round-robin
    // pointer just past the departing owner, which becomes lowest priority.
    // TURNAR counts down TURN-1 .. 0 and looks at req only on its final edge.
    always_comb begin
        state_nxt      = state;
        ptr_nxt        = ptr;
        tenure_cnt_nxt = tenure_cnt;
        turn_cnt_nxt   = turn_cnt;
        grant_nxt      = grant_q;
        owner_nxt      = owner_q;
        case (state)
            IDLE: begin
                if (armed && found) begin
                    state_nxt      = OWN;
                    grant_nxt      = 4'b0001 << winner;
                    owner_nxt      = winner;
                    tenure_cnt_nxt = 8'd1;
                end
            end
            OWN: begin
                if (!bus.req[owner_q] ||
                    (tenure_cnt == TENURE_MAX && others_pending)) begin
                    state_nxt    = TURNAR;
                    grant_nxt    = '0;
                    owner_nxt    = '0;
                    ptr_nxt      = owner_q + 2'd1;
                    turn_cnt_nxt = TURN_LAST;
                end else if (tenure_cnt != TENURE_MAX) begin
                    tenure_cnt_nxt = tenure_cnt + 8'd1;
                end
            end
            TURNAR: begin
                if (turn_cnt == 4'd0) begin
                    if (found) begin
                        state_nxt      = OWN;
                        grant_nxt      = 4'b0001 << winner;
                        owner_nxt      = winner;
                        tenure_cnt_nxt = 8'd1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    turn_cnt_nxt = turn_cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
                owner_nxt = '0;
            end
        endcase
    end

    // State and output registers; reset clears everything immediately,
    // whatever the arbiter was doing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ptr        <= '0;
            tenure_cnt <= '0;
            turn_cnt   <= '0;
            grant_q    <= '0;
            owner_q    <= '0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            tenure_cnt <= tenure_cnt_nxt;
            turn_cnt   <= turn_cnt_nxt;
            grant_q    <= grant_nxt;
            owner_q    <= owner_nxt;
        end
    end

    // grant and oe come from the same register, so they can never disagree.
    assign bus.grant    = grant_q;
    assign bus.oe       = grant_q;
    assign bus.owner    = owner_q;
    assign bus.bus_busy = |grant_q;
    assign bus.turn     = (state == TURNAR);

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_tri_bus_arbiter
// Scoreboard bench for tri_bus_arbiter. Two instances share clk/rst_n:
// dut_a (TENURE=8, TURN=1) and dut_b (TENURE=8, TURN=3). Each scenario queues
// the expected per-cycle oe/turn pattern, then drives req one cycle at a time
// and compares the whole output set halfway through every cycle.
// ---------------------------------------------------------------------------
module tb_tri_bus_arbiter;

    typedef struct packed {
        logic [3:0] oe;
        logic       turn;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    exp_t exp_q[$];
    int   check_count = 0;
    int   pass_count  = 0;
    logic [3:0] prev_oe_a = '0;
    logic [3:0] prev_oe_b = '0;

    tri_bus_arbiter_if bus_a ();
    tri_bus_arbiter_if bus_b ();

    tri_bus_arbiter #(.TENURE(8), .TURN(1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    tri_bus_arbiter #(.TENURE(8), .TURN(3)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [11:0] actual,
                               input logic [11:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %03h, expected %03h (grant,oe,owner,busy,turn)",
                     tag, actual, expected);
        end
    endtask

    // Packs the observable outputs of each instance into one vector.
    function automatic logic [11:0] vecA();
        return {bus_a.grant, bus_a.oe, bus_a.owner, bus_a.bus_busy, bus_a.turn};
    endfunction

    function automatic logic [11:0] vecB();
        return {bus_b.grant, bus_b.oe, bus_b.owner, bus_b.bus_busy, bus_b.turn};
    endfunction

    // Expands an expected oe/turn pair into the full output vector.
    function automatic logic [11:0] expVector(input exp_t e);
        logic [1:0] own;
        own = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (e.oe[i]) own = 2'(i);
        end
        return {e.oe, e.oe, own, |e.oe, e.turn};
    endfunction

    // Queues n cycles of the same expected pattern.
    task automatic pushExp(input int n, input logic [3:0] oe, input logic t);
        exp_t e;
        e.oe   = oe;
        e.turn = t;
        repeat (n) exp_q.push_back(e);
    endtask

    // Drives req for n cycles; after each rising edge, pops the expected
    // pattern and compares it against the chosen instance.
    task automatic applyStimulus(input string tag, input bit use_b,
                                 input logic [3:0] r, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            if (use_b) bus_b.req = r;
            else       bus_a.req = r;
            @(posedge clk);
            @(negedge clk);
            if (exp_q.size() == 0) begin
                checkOutput({tag, " underflow"}, 12'(exp_q.size()), 12'd1);
            end else begin
                e = exp_q.pop_front();
                checkOutput($sformatf("%s c%0d", tag, i + 1),
                            use_b ? vecB() : vecA(), expVector(e));
            end
        end
    endtask

    // Continuous rule: at most one oe bit, oe equal to grant, and no two
    // different owners in adjacent cycles.
    function automatic bit oeRuleOk(input logic [3:0] g, input logic [3:0] oe,
                                    input logic [3:0] prev);
        return ($countones(oe) <= 1) && (oe == g) &&
               !(prev != 4'd0 && oe != 4'd0 && prev != oe);
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            checkOutput("oe_rule_a", 12'(oeRuleOk(bus_a.grant, bus_a.oe, prev_oe_a)), 12'd1);
            checkOutput("oe_rule_b", 12'(oeRuleOk(bus_b.grant, bus_b.oe, prev_oe_b)), 12'd1);
        end
        prev_oe_a = bus_a.oe;
        prev_oe_b = bus_b.oe;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Scenario sequence.
    initial begin
        int order [5];
        order = '{0, 1, 2, 3, 0};

        rst_n     = 1'b0;
        bus_a.req = '0;
        bus_b.req = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_a", vecA(), 12'h000);
        checkOutput("reset_b", vecB(), 12'h000);
        rst_n = 1'b1;
        pushExp(2, 4'b0000, 1'b0);
        applyStimulus("wake", 1'b0, 4'b0000, 2);

        // All four requesting: owners 0,1,2,3,0 for 8 cycles each, 1 dead cycle.
        for (int k = 0; k < 5; k++) begin
            pushExp(8, 4'b0001 << order[k], 1'b0);
            pushExp(1, 4'b0000, 1'b1);
        end
        pushExp(2, 4'b0000, 1'b0);
        applyStimulus("rr4", 1'b0, 4'b1111, 45);
        applyStimulus("rr4_end", 1'b0, 4'b0000, 2);
        checkOutput("rr4_drain", 12'(exp_q.size()), 12'd0);

        // Single requester for 3 cycles, voluntary release.
        pushExp(3, 4'b0001, 1'b0);
        pushExp(1, 4'b0000, 1'b1);
        pushExp(2, 4'b0000, 1'b0);
        applyStimulus("single", 1'b0, 4'b0001, 3);
        applyStimulus("single_end", 1'b0, 4'b0000, 3);
        checkOutput("single_drain", 12'(exp_q.size()), 12'd0);

        // Lone owner keeps the bus past TENURE, then is forced out by 1;
        // owner 1 releases as 0 and 3 arrive, 3 wins from ptr=2.
        pushExp(20, 4'b0100, 1'b0);
        pushExp(1, 4'b0000, 1'b1);
        pushExp(3, 4'b0010, 1'b0);
        pushExp(1, 4'b0000, 1'b1);
        pushExp(2, 4'b1000, 1'b0);
        pushExp(1, 4'b0000, 1'b1);
        pushExp(1, 4'b0000, 1'b0);
        applyStimulus("hold", 1'b0, 4'b0100, 20);
        applyStimulus("force", 1'b0, 4'b0110, 2);
        applyStimulus("own1", 1'b0, 4'b0010, 2);
        applyStimulus("rel1", 1'b0, 4'b1001, 3);
        applyStimulus("rel3", 1'b0, 4'b0000, 2);
        checkOutput("hold_drain", 12'(exp_q.size()), 12'd0);

        // Asynchronous reset mid-tenure, then the wake-up edge before a grant.
        pushExp(4, 4'b0100, 1'b0);
        applyStimulus("pre_rst", 1'b0, 4'b0100, 4);
        #2;
        rst_n     = 1'b0;
        bus_a.req = 4'b0010;
        #1;
        checkOutput("async_rst_a", vecA(), 12'h000);
        @(negedge clk);
        checkOutput("held_rst_a", vecA(), 12'h000);
        rst_n = 1'b1;
        pushExp(1, 4'b0000, 1'b0);
        pushExp(3, 4'b0010, 1'b0);
        pushExp(1, 4'b0000, 1'b1);
        pushExp(1, 4'b0000, 1'b0);
        applyStimulus("post_rst", 1'b0, 4'b0010, 4);
        applyStimulus("post_rst_end", 1'b0, 4'b0000, 2);
        checkOutput("rst_drain", 12'(exp_q.size()), 12'd0);

        // TURN=3 instance: 3 dead cycles between owners; req changes inside
        // the turnaround are ignored, only the final-edge value (1000) counts.
        pushExp(8, 4'b0001, 1'b0);
        pushExp(3, 4'b0000, 1'b1);
        pushExp(8, 4'b0010, 1'b0);
        pushExp(3, 4'b0000, 1'b1);
        pushExp(8, 4'b0001, 1'b0);
        pushExp(3, 4'b0000, 1'b1);
        pushExp(3, 4'b1000, 1'b0);
        pushExp(3, 4'b0000, 1'b1);
        pushExp(1, 4'b0000, 1'b0);
        applyStimulus("turn3", 1'b1, 4'b0011, 31);
        applyStimulus("turn3_gap0", 1'b1, 4'b0000, 1);
        applyStimulus("turn3_gap1", 1'b1, 4'b0100, 1);
        applyStimulus("turn3_own3", 1'b1, 4'b1000, 3);
        applyStimulus("turn3_end", 1'b1, 4'b0000, 4);
        checkOutput("turn3_drain", 12'(exp_q.size()), 12'd0);

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
